// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the single-clock byte FIFO.
// Imported by fifo_ram and fifo_generator.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEFAULT = 8;
  localparam int FIFO_DEPTH_DEFAULT = 16;

  // Smallest w with 2**w >= depth; pointers use exactly this many bits.
  function automatic int fifo_ptr_width(input int depth);
    int w;
    w = 0;
    while ((32'd1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port, registered synchronous read port.
// Only the read data register is reset so the array can map onto block RAM.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH_DEFAULT,
  parameter int DEPTH  = FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W = fifo_ptr_width(FIFO_DEPTH_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register holds its value unless a read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_generator.sv
// Single-clock synchronous FIFO (standard mode, one-cycle registered read latency).
// Define FIFO_DATA_COUNT_EN to expose the internal occupancy as data_count.
module fifo_generator
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
`ifdef FIFO_DATA_COUNT_EN
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  data_count
`else
  output logic                    empty
`endif
);

  localparam int PTR_W = fifo_ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CNT_W-1:0] w_count_next;

  // Overflow and underflow requests are simply not accepted.
  assign w_wr_acc = wr_en && !r_full;
  assign w_rd_acc = rd_en && !r_empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_next;
      // Flags come from the next count so they line up with r_count.
      r_full  <= (w_count_next == DEPTH_CNT);
      r_empty <= (w_count_next == '0);
    end
  end

  fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wptr),
    .i_wr_data (din),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rptr),
    .o_rd_data (dout)
  );

  assign full  = r_full;
  assign empty = r_empty;

`ifdef FIFO_DATA_COUNT_EN
  assign data_count = r_count;
`endif

endmodule

// File: tb/tb_fifo_generator.sv
// Directed scoreboard bench for fifo_generator; a queue models storage and a
// second queue holds expected read data popped when dout becomes valid.
module tb_fifo_generator;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;
`ifdef FIFO_DATA_COUNT_EN
  logic [4:0] data_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] m_store[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_dout;

  fifo_generator #(.WIDTH(8), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
`ifdef FIFO_DATA_COUNT_EN
    ,.data_count (data_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive one cycle, then compare flags and dout at the next negedge.
  task automatic step(input logic we, input logic re, input logic [7:0] d);
    logic wa;
    logic ra;
    wa = we && (m_store.size() != 16);
    ra = re && (m_store.size() != 0);
    wr_en = we;
    rd_en = re;
    din   = d;
    if (ra) exp_q.push_back(m_store.pop_front());
    if (wa) m_store.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (ra) m_dout = exp_q.pop_front();
    $display("t=%0t wr=%0b rd=%0b din=%02h -> dout=%02h full=%0b empty=%0b cnt=%0d",
             $time, we, re, d, dout, full, empty, m_store.size());
    check("dout", {24'd0, dout}, {24'd0, m_dout});
    check("full", {31'd0, full}, {31'd0, (m_store.size() == 16)});
    check("empty", {31'd0, empty}, {31'd0, (m_store.size() == 0)});
`ifdef FIFO_DATA_COUNT_EN
    check("data_count", {27'd0, data_count}, m_store.size());
`endif
  endtask

  // Asynchronous 20 ns reset pulse starting 2 ns after a negedge, checked before any clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    m_store.delete();
    exp_q.delete();
    m_dout = 8'h00;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
`ifdef FIFO_DATA_COUNT_EN
    check("rst_count", {27'd0, data_count}, 32'd0);
`endif
    #19 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    m_dout = 8'h00;
    async_reset();

    // Fill 1..16, one write every three cycles.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
    end
    step(1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);

    // Underflow holds dout at 16.
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    check("underflow_hold", {24'd0, dout}, 32'd16);

    // Order across pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);

    // Simultaneous read/write with 5 entries keeps the count at 5.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h70 + i));
    check("simul_count", m_store.size(), 32'd5);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    step(1'b1, 1'b1, 8'hBB);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00);

    // Both requests while empty: only the write lands.
    step(1'b1, 1'b1, 8'hC5);
    step(1'b0, 1'b1, 8'h00);

    // Reset mid-operation, then resume.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hD0 + i));
    async_reset();
    step(1'b1, 1'b0, 8'hE7);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
